// File: rtl/aes_inv_cipher_iter_if.sv
// Block/handshake bundle between the AES inverse cipher core and its environment:
// ciphertext in, round-key fetch, plaintext out and status.
interface aes_inv_cipher_iter_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [CNT_W-1:0] rk_idx;
  logic [127:0]     rk_in;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             busy;
  logic [CNT_W-1:0] round_count;

  modport master (
    output in_valid, in_data, rk_in, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy, round_count
  );

  modport slave (
    input  in_valid, in_data, rk_in, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy, round_count
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, NR = 10/12/14, round keys
// fetched combinationally through rk_idx/rk_in.
module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  aes_inv_cipher_iter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] NR_CNT   = CNT_W'(NR);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NR - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end
  if ((1 << CNT_W) <= NR) begin : g_bad_cnt_w
    $error("aes_inv_cipher_iter: CNT_W too narrow for NR");
  end

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x09/0x0b/0x0d/0x0e: all share the x8 term, low bits of c pick the rest.
  function automatic logic [7:0] gmul_inv(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction

  logic [1:0]       fsm_reg;
  logic [127:0]     state_reg;
  logic [127:0]     out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [127:0]     sub_bytes;
  logic [127:0]     add_key;
  logic [127:0]     mix_cols;
  logic [127:0]     round_next;
  logic             accept;

  // InvShiftRows folded into the S-box input selection: byte (r,c) takes (r,c-r).
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_sub
    localparam int SRC = (gi % 4) + 4 * (((gi / 4) - (gi % 4) + 4) % 4);
    assign sub_bytes[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]);
  end

  assign add_key = sub_bytes ^ bus.rk_in;

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = add_key[127-32*gi -: 8];
    assign a1 = add_key[119-32*gi -: 8];
    assign a2 = add_key[111-32*gi -: 8];
    assign a3 = add_key[103-32*gi -: 8];
    assign mix_cols[127-32*gi -: 32] = {
      gmul_inv(a0, 4'he) ^ gmul_inv(a1, 4'hb) ^ gmul_inv(a2, 4'hd) ^ gmul_inv(a3, 4'h9),
      gmul_inv(a0, 4'h9) ^ gmul_inv(a1, 4'he) ^ gmul_inv(a2, 4'hb) ^ gmul_inv(a3, 4'hd),
      gmul_inv(a0, 4'hd) ^ gmul_inv(a1, 4'h9) ^ gmul_inv(a2, 4'he) ^ gmul_inv(a3, 4'hb),
      gmul_inv(a0, 4'hb) ^ gmul_inv(a1, 4'hd) ^ gmul_inv(a2, 4'h9) ^ gmul_inv(a3, 4'he)
    };
  end

  assign round_next = (fsm_reg == FINAL) ? add_key : mix_cols;

  assign bus.in_ready    = !abort && ((fsm_reg == IDLE) || ((fsm_reg == DONE) && bus.out_ready));
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = (fsm_reg == DONE);
  assign bus.out_data    = out_reg;
  assign bus.busy        = (fsm_reg == ROUND) || (fsm_reg == FINAL);
  assign bus.round_count = cnt_reg;

  // The last-round key is presented while waiting so the initial AddRoundKey needs no extra cycle.
  always_comb begin
    bus.rk_idx = NR_CNT;
    case (fsm_reg)
      ROUND:   bus.rk_idx = cnt_reg;
      FINAL:   bus.rk_idx = '0;
      default: bus.rk_idx = NR_CNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      out_reg   <= '0;
      cnt_reg   <= '0;
    end else if (abort) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      cnt_reg   <= NR_CNT;
    end else if (accept) begin
      state_reg <= bus.in_data ^ bus.rk_in;
      cnt_reg   <= LAST_CNT;
      fsm_reg   <= ROUND;
    end else begin
      case (fsm_reg)
        ROUND: begin
          state_reg <= round_next;
          cnt_reg   <= cnt_reg - ONE_CNT;
          if (cnt_reg == ONE_CNT) fsm_reg <= FINAL;
        end
        FINAL: begin
          state_reg <= round_next;
          out_reg   <= round_next;
          cnt_reg   <= NR_CNT;
          fsm_reg   <= DONE;
        end
        DONE: begin
          if (bus.out_ready) fsm_reg <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher core that decrypts one 128-bit block per request, one round per clock, for a parameterised key length (AES-128/192/256).
- Generalises the fixed 10-round decryption block.
- Adds ready/valid handshakes on input and output, an external round-key fetch port, back-to-back operation and a synchronous abort.
- Sits between the SD data-path buffer and the round-key store. The key store answers rk_idx combinationally.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14 (any other value is an elaboration error via a static assertion).
CNT_W, 4, width of round counter and rk_idx; must satisfy 2**CNT_W > NR.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous active-high reset.
abort  input  1  synchronous abort; returns core to IDLE, discards block.
in_valid  input  1  ciphertext block offered.
in_ready  output  1  core can accept a block this cycle.
in_data  input  128  ciphertext, byte 0 in bits [127:120].
rk_idx  output  CNT_W  index of round key needed this cycle.
rk_in  input  128  round key rk[rk_idx], valid same cycle (combinational return).
out_valid  output  1  plaintext available.
out_ready  input  1  consumer takes plaintext.
out_data  output  128  plaintext; stable while out_valid && !out_ready.
busy  output  1  high in LOAD-free states ROUND and FINAL.
round_count  output  CNT_W  current round index (debug/status).

Behaviour:
- States: IDLE, ROUND, FINAL, DONE. One 128-bit state register and one CNT_W round counter.
- Reset (rst=1 at edge): state IDLE, state register 0, round_count 0, out_data 0, out_valid 0, busy 0. in_ready=1 in the first cycle after reset.
- in_ready = (IDLE) or (DONE && out_ready). Accept = in_valid && in_ready.
- rk_idx:
  - NR in IDLE and DONE, so the initial key is pre-presented.
  - round_count in ROUND.
  - 0 in FINAL.
- On accept (edge T):
  - state <= in_data ^ rk_in, i.e. the initial AddRoundKey with rk[NR].
  - round_count <= NR-1; go to ROUND.
- ROUND, one cycle per round for r = NR-1 down to 1:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - round_count decrements.
  - When r == 1 the next state is FINAL.
- FINAL: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go to DONE.
- DONE:
  - out_valid=1, out_data=state.
  - Hold until out_ready.
  - On out_ready without accept: go to IDLE.
  - On out_ready with simultaneous accept: load the new block and go to ROUND (no bubble).
- Latency: out_valid rises at T+NR+1 (11/13/15 cycles after the accept edge). Back-to-back throughput is one block per NR+1 cycles.
- busy=1 exactly in ROUND and FINAL. round_count reads NR in IDLE and DONE, and 0 in FINAL.
- InvSubBytes is 16 parallel inverse S-box lookups; InvShiftRows and InvMixColumns follow FIPS-197; all GF(2^8) arithmetic uses modulus 0x11B. No pipelining inside a round.
- in_data is sampled only on the accept edge; changes while busy are ignored.
- in_valid with in_ready=0: no effect; the upstream must hold in_data.
- abort:
  - Any state goes to IDLE next cycle; out_valid drops next cycle; state register is cleared to 0.
  - abort has priority over accept and over output handoff in the same cycle.
  - in_ready is forced 0 in the abort cycle.
- rst has priority over abort. Reset mid-operation drops the block silently, with no out_valid pulse.
- out_data retains its value after handoff until the next FINAL edge.

Test Plan:
1. NR=10, rk from key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_data 00112233445566778899aabbccddeeff, out_valid at T+11, busy high for 10 cycles.
2. NR=12, key 000102…1617, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233…eeff at T+13. NR=14, key 000102…1e1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> 00112233…eeff at T+15.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, rk_idx=NR. Then assert out_ready with in_valid=1 -> second block accepted same edge, second result 11 cycles later.
4. Abort at round_count=5 -> IDLE next cycle, no out_valid, in_ready=1. A following vector decrypts correctly.
5. rst asserted mid-ROUND and in DONE -> all outputs at reset values next cycle. Simultaneous rst+abort+accept -> reset wins.
6. rk_idx trace for NR=10 -> 10 (accept), 9,8,…,1, 0 (FINAL), 10 (DONE), checked against a reference round-key model every cycle.
